// File: rtl/serial_feeder_pkg.sv
//==============================================================================
// Module  : serial_feeder_pkg
// Brief   : Shared state encoding and widths for the serial word feeder.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package serial_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam int GAP_CNT_W = 4;
    localparam int WORDS_W   = 16;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg.sv
//==============================================================================
// Module  : piso_shift_reg
// Brief   : Parallel-load shift register with selectable bit order.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             msb_first,
    input  logic [WIDTH-1:0] data,
    output logic             bit_next
);

    logic [WIDTH-1:0] shreg;
    logic             msb_order;

    // The register holds only the bits not yet handed out; bit_next is the
    // bit the caller should register on the current edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            msb_order <= 1'b0;
        end else if (load) begin
            shreg     <= msb_first ? (data << 1) : (data >> 1);
            msb_order <= msb_first;
        end else if (shift) begin
            shreg     <= msb_order ? (shreg << 1) : (shreg >> 1);
        end
    end

    assign bit_next = load ? (msb_first ? data[WIDTH-1] : data[0])
                           : (msb_order ? shreg[WIDTH-1] : shreg[0]);

endmodule

`default_nettype wire

// File: rtl/serial_word_feeder.sv
//==============================================================================
// Module  : serial_word_feeder
// Brief   : Valid/ready word input serialised one bit per clk; optional even
//           parity bit per word enabled by SERIAL_FEEDER_PARITY_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_word_feeder
    import serial_feeder_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               msb_first,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               frame_start,
    output logic               busy,
    output logic [WORDS_W-1:0] words_sent
);

    localparam int                   CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [GAP_CNT_W-1:0]  gap_cnt;
    logic                  last_bit;
    logic                  word_end;
    logic                  accept;
    logic                  bit_next;

    assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);
`ifdef SERIAL_FEEDER_PARITY_EN
    assign word_end = (state == ST_PARITY);
`else
    assign word_end = last_bit;
`endif

    // Ready in the final emitted cycle only without a gap, so words stream
    // back-to-back with no idle bit between them.
    assign in_ready = (state == ST_IDLE) || ((GAP == 0) && word_end);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);

    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    ((state == ST_SHIFT) && !last_bit),
        .msb_first(msb_first),
        .data     (in_data),
        .bit_next (bit_next)
    );

`ifdef SERIAL_FEEDER_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (accept) begin
            par_bit <= ^in_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            ser_out     <= IDLE_BIT;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            words_sent  <= '0;
        end else begin
            frame_start <= 1'b0;
            if (accept) begin
                state       <= ST_SHIFT;
                bit_cnt     <= '0;
                ser_out     <= bit_next;
                ser_valid   <= 1'b1;
                frame_start <= 1'b1;
            end else if (word_end) begin
                state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
                gap_cnt   <= '0;
                ser_out   <= IDLE_BIT;
                ser_valid <= 1'b0;
            end else begin
                case (state)
                    ST_SHIFT: begin
`ifdef SERIAL_FEEDER_PARITY_EN
                        if (last_bit) begin
                            state   <= ST_PARITY;
                            ser_out <= par_bit;
                        end else
`endif
                        begin
                            bit_cnt <= bit_cnt + 1'b1;
                            ser_out <= bit_next;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (word_end) begin
                words_sent <= words_sent + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_word_feeder.sv
//==============================================================================
// Module  : tb_serial_word_feeder
// Brief   : Self-checking bench for serial_word_feeder (GAP=0 and GAP=2 units).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_word_feeder;

    localparam int   W      = 8;
    localparam int   NDUT   = 2;
    localparam int   MAXE   = 32;
    localparam logic IDLE_B = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int   PAR    = 1;
`else
    localparam int   PAR    = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          msb_first = 1'b0;
    logic          rdy [NDUT];
    logic          so  [NDUT];
    logic          sv  [NDUT];
    logic          fs  [NDUT];
    logic          bsy [NDUT];
    logic [15:0]   ws  [NDUT];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(W), .GAP(0), .IDLE_BIT(IDLE_B)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .msb_first(msb_first), .ser_out(so[0]),
        .ser_valid(sv[0]), .frame_start(fs[0]), .busy(bsy[0]), .words_sent(ws[0])
    );

    serial_word_feeder #(.WIDTH(W), .GAP(2), .IDLE_BIT(IDLE_B)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .msb_first(msb_first), .ser_out(so[1]),
        .ser_valid(sv[1]), .frame_start(fs[1]), .busy(bsy[1]), .words_sent(ws[1])
    );

    // Reference model: a timeline of the output cycles still owed per unit.
    logic       m_v    [NDUT][MAXE];
    logic       m_b    [NDUT][MAXE];
    logic       m_fs   [NDUT][MAXE];
    logic       m_last [NDUT][MAXE];
    int         m_n    [NDUT];
    logic [15:0] m_ws  [NDUT];

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic m_ready(input int k);
        return (m_n[k] == 0) || ((gap_of(k) == 0) && (m_n[k] == 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic v, input logic b, input logic f, input logic l);
        m_v[k][m_n[k]]    = v;
        m_b[k][m_n[k]]    = b;
        m_fs[k][m_n[k]]   = f;
        m_last[k][m_n[k]] = l;
        m_n[k]++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_n[k]  = 0;
            m_ws[k] = '0;
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < NDUT; k++) begin
            logic ev, eb, ef;
            ev = (m_n[k] > 0) ? m_v[k][0]  : 1'b0;
            eb = (m_n[k] > 0) ? m_b[k][0]  : IDLE_B;
            ef = (m_n[k] > 0) ? m_fs[k][0] : 1'b0;
            chk($sformatf("u%0d ser_valid", k),   32'(sv[k]),  32'(ev));
            chk($sformatf("u%0d ser_out", k),     32'(so[k]),  32'(eb));
            chk($sformatf("u%0d frame_start", k), 32'(fs[k]),  32'(ef));
            chk($sformatf("u%0d busy", k),        32'(bsy[k]), 32'(m_n[k] > 0));
            chk($sformatf("u%0d in_ready", k),    32'(rdy[k]), 32'(m_ready(k)));
            chk($sformatf("u%0d words_sent", k),  32'(ws[k]),  32'(m_ws[k]));
        end
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d, input logic m);
        for (int k = 0; k < NDUT; k++) begin
            logic acc;
            acc = v && m_ready(k);
            if (m_n[k] > 0) begin
                if (m_last[k][0]) m_ws[k] = m_ws[k] + 16'd1;
                for (int i = 0; i < m_n[k] - 1; i++) begin
                    m_v[k][i]    = m_v[k][i+1];
                    m_b[k][i]    = m_b[k][i+1];
                    m_fs[k][i]   = m_fs[k][i+1];
                    m_last[k][i] = m_last[k][i+1];
                end
                m_n[k]--;
            end
            if (acc) begin
                for (int j = 0; j < W; j++)
                    push(k, 1'b1, m ? d[W-1-j] : d[j], j == 0, (j == W-1) && (PAR == 0));
                if (PAR != 0) push(k, 1'b1, ^d, 1'b0, 1'b1);
                for (int g = 0; g < gap_of(k); g++) push(k, 1'b0, IDLE_B, 1'b0, 1'b0);
            end
        end
    endtask

    // Called at a falling edge: check, drive, take the rising edge, advance.
    task automatic step(input logic v, input logic [W-1:0] d, input logic m);
        model_check();
        in_valid  = v;
        in_data   = d;
        msb_first = m;
        @(posedge clk);
        model_step(v, d, m);
        @(negedge clk);
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         m;
        logic         eo, ev, ef;
        logic [15:0]  ews;
        logic         erdy, ebusy;
    } vec_t;

    vec_t vt [128];
    int   nv = 0;

    task automatic add(input logic v, input logic [W-1:0] d, input logic m,
                       input logic eo, input logic ev, input logic ef,
                       input logic [15:0] ews, input logic erdy, input logic ebusy);
        vt[nv] = '{v, d, m, eo, ev, ef, ews, erdy, ebusy};
        nv++;
    endtask

    // seq lists the emitted bits in order, first bit in seq[W-1].
    task automatic add_word(input logic [W-1:0] seq, input logic par,
                            input logic hv, input logic [W-1:0] hd,
                            input logic fv, input logic [W-1:0] fd,
                            input logic [15:0] wsv);
        for (int k = 0; k < W; k++) begin
            logic fin;
            fin = (k == W-1) && (PAR == 0);
            add(fin ? fv : hv, fin ? fd : hd, 1'b0, seq[W-1-k], 1'b1, k == 0, wsv, fin, 1'b1);
        end
        if (PAR != 0) add(fv, fd, 1'b0, par, 1'b1, 1'b0, wsv, 1'b1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ws_before;

        add(1'b1, 8'hD6, 1'b1, IDLE_B, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        add_word(8'b1101_0110, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd0);
        add(1'b1, 8'hA5, 1'b0, IDLE_B, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0);
        add_word(8'b1010_0101, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, 16'd1);
        add_word(8'b0011_1100, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'd2);
        for (int i = 0; i < 5; i++)
            add(1'b0, 8'(i * 37 + 5), 1'b1, IDLE_B, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0);
        add(1'b1, 8'h07, 1'b0, IDLE_B, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0);
        add_word(8'b1110_0000, 1'b1, 1'b1, 8'h03, 1'b1, 8'h03, 16'd3);
        add_word(8'b1100_0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'd4);
        add(1'b0, 8'h00, 1'b0, IDLE_B, 1'b0, 1'b0, 16'd5, 1'b1, 1'b0);

        // Reset values while rst is held
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("rst u%0d ser_out", k),     32'(so[k]),  32'(IDLE_B));
            chk($sformatf("rst u%0d ser_valid", k),   32'(sv[k]),  32'd0);
            chk($sformatf("rst u%0d frame_start", k), 32'(fs[k]),  32'd0);
            chk($sformatf("rst u%0d busy", k),        32'(bsy[k]), 32'd0);
            chk($sformatf("rst u%0d words_sent", k),  32'(ws[k]),  32'd0);
        end
        rst = 1'b0;
        model_reset();

        // Directed table on the GAP=0 unit; the model tracks both units
        for (int i = 0; i < nv; i++) begin
            chk($sformatf("tbl[%0d] ser_out", i),     32'(so[0]),  32'(vt[i].eo));
            chk($sformatf("tbl[%0d] ser_valid", i),   32'(sv[0]),  32'(vt[i].ev));
            chk($sformatf("tbl[%0d] frame_start", i), 32'(fs[0]),  32'(vt[i].ef));
            chk($sformatf("tbl[%0d] words_sent", i),  32'(ws[0]),  32'(vt[i].ews));
            chk($sformatf("tbl[%0d] in_ready", i),    32'(rdy[0]), 32'(vt[i].erdy));
            chk($sformatf("tbl[%0d] busy", i),        32'(bsy[0]), 32'(vt[i].ebusy));
            step(vt[i].v, vt[i].d, vt[i].m);
        end

        // Randomised traffic, including bit-order toggles mid-word
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom));

        // Reset during the fourth bit of 8'hFF
        for (int i = 0; i < 16; i++) step(1'b0, W'($urandom), 1'b0);
        step(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        ws_before = ws[0];
        chk("pre-rst u0 ser_valid", 32'(sv[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("midrst u%0d ser_out", k),    32'(so[k]),  32'(IDLE_B));
            chk($sformatf("midrst u%0d ser_valid", k),  32'(sv[k]),  32'd0);
            chk($sformatf("midrst u%0d busy", k),       32'(bsy[k]), 32'd0);
            chk($sformatf("midrst u%0d words_sent", k), 32'(ws[k]),  32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("post-rst u0 words_sent", 32'(ws[0]), 32'd0);
        chk("pre-rst count nonzero", 32'(ws_before != 16'd0), 32'd1);
        step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b0);
        chk("after-rst word u0 count", 32'(ws[0]), 32'd1);
        chk("after-rst word u2 count", 32'(ws[1]), 32'd1);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) != 0, W'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
